// File: rtl/mem_access_unit.sv
// MEM-stage access unit: EX/MEM request to req/ack data-memory port with stall.
// Optional MEM_ALIGN_CHECK_EN rejects misaligned accesses without a memory request.
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        err_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Counter holds the number of BUSY cycles already spent.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0] state;
  logic [7:0] cnt;
  logic       access;
  logic       timeout;
  logic       misalign;

  assign access  = MemRead_i | MemWrite_i;
  assign stall   = access & (state != DONE);
  assign timeout = (cnt == CNT_LAST);

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = (addr_i[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      rdata_o   <= 32'd0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (access && misalign) begin
            state  <= DONE;
            done_o <= 1'b1;
            err_o  <= 1'b1;
            if (!MemWrite_i)
              rdata_o <= 32'd0;
          end else if (access) begin
            state     <= BUSY;
            cnt       <= 8'd0;
            mem_req   <= 1'b1;
            mem_we    <= MemWrite_i;
            mem_addr  <= addr_i;
            mem_wdata <= wdata_i;
          end
        end
        BUSY: begin
          cnt <= cnt + 8'd1;
          // An ack arriving on the timeout cycle still completes normally.
          if (mem_ack) begin
            state   <= DONE;
            mem_req <= 1'b0;
            done_o  <= 1'b1;
            if (!mem_we)
              rdata_o <= mem_rdata;
          end else if (timeout) begin
            state   <= DONE;
            mem_req <= 1'b0;
            done_o  <= 1'b1;
            err_o   <= 1'b1;
            rdata_o <= 32'd0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed table, corner sequences, random ops.
// Expected values come from a transaction-level model of the access rules.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead_i, MemWrite_i;
  logic [31:0] addr_i, wdata_i;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall;
  logic [31:0] rdata_o;
  logic        done_o, err_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] last_rd = 32'd0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(stall), .rdata_o(rdata_o),
    .done_o(done_o), .err_o(err_o)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          dly;
    logic [31:0] rin;
    bit          stray;
    int          exp_req;
    int          exp_stall;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level expectations: dly is the mem_req cycle carrying ack,
  // 0 means the memory never answers.
  task automatic model(input logic rd, input logic wr, input logic [31:0] a,
                       input int dly, input logic [31:0] rin,
                       input logic [31:0] prev,
                       output int er, output int es, output bit ee,
                       output logic [31:0] erd);
    bit mis = 1'b0;
    bit to;
`ifdef MEM_ALIGN_CHECK_EN
    mis = (a[1:0] != 2'b00);
`endif
    if (mis) begin
      er  = 0;
      es  = 1;
      ee  = 1'b1;
      erd = (rd && !wr) ? 32'd0 : prev;
    end else begin
      to  = (dly == 0) || (dly > TO);
      er  = to ? TO : dly;
      es  = er + 1;
      ee  = to;
      erd = to ? 32'd0 : (wr ? prev : rin);
    end
  endtask

  task automatic run_op(input vec_t v);
    int  reqc = 0;
    int  stallc = 0;
    int  cyc = 0;
    bit  seen = 1'b0;
    bit  hold_ok = 1'b1;
    MemRead_i  = v.rd;
    MemWrite_i = v.wr;
    addr_i     = v.addr;
    wdata_i    = v.wdata;
    mem_ack    = 1'b0;
    while (!seen && cyc < 400) begin
      #1;
      if (done_o) begin
        seen = 1'b1;
        chk("req_cycles", reqc, v.exp_req);
        chk("stall_cycles", stallc, v.exp_stall);
        chk("err", {31'd0, err_o}, {31'd0, v.exp_err});
        chk("rdata", rdata_o, v.exp_rdata);
        chk("hold", {31'd0, hold_ok}, 32'd1);
        chk("done_stall", {31'd0, stall}, 32'd0);
        if (v.stray) begin
          mem_ack   = 1'b1;
          mem_rdata = 32'hFFFF_0000;
        end
      end else begin
        if (stall) stallc++;
        if (mem_req) begin
          reqc++;
          if (mem_addr !== v.addr || mem_we !== v.wr ||
              mem_wdata !== v.wdata)
            hold_ok = 1'b0;
          if (reqc == v.dly) begin
            mem_ack   = 1'b1;
            mem_rdata = v.rin;
          end
        end
      end
      @(posedge clk);
      #1;
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      cyc++;
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
    if (v.stray) begin
      #1;
      chk("stray_done", {31'd0, done_o}, 32'd0);
      chk("stray_req", {31'd0, mem_req}, 32'd0);
      chk("stray_rdata", rdata_o, v.exp_rdata);
      @(posedge clk);
      #1;
    end
    last_rd = v.exp_rdata;
  endtask

  vec_t tbl[8];
  vec_t r;

  initial begin
    rst = 1'b1;
    MemRead_i = 1'b0; MemWrite_i = 1'b0;
    addr_i = 32'd0; wdata_i = 32'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0;

    tbl[0] = '{1, 0, 32'h100, 32'h0, 3, 32'hDEADBEEF, 0, 3, 4, 0, 32'hDEADBEEF};
    tbl[1] = '{0, 1, 32'h200, 32'h12345678, 1, 32'h1111, 0, 1, 2, 0, 32'hDEADBEEF};
    tbl[2] = '{1, 0, 32'h300, 32'h0, 2, 32'hA5A50001, 1, 2, 3, 0, 32'hA5A50001};
    tbl[3] = '{1, 0, 32'h304, 32'h0, 1, 32'h0BADF00D, 0, 1, 2, 0, 32'h0BADF00D};
    tbl[4] = '{1, 0, 32'h308, 32'h0, 0, 32'h0, 0, 4, 5, 1, 32'h0};
    tbl[5] = '{1, 1, 32'h010, 32'hCAFE0001, 4, 32'h2222, 0, 4, 5, 0, 32'h0};
    tbl[6] = '{1, 0, 32'h30C, 32'h0, 4, 32'h000055AA, 0, 4, 5, 0, 32'h55AA};
`ifdef MEM_ALIGN_CHECK_EN
    tbl[7] = '{1, 0, 32'h102, 32'h0, 2, 32'h77, 0, 0, 1, 1, 32'h0};
`else
    tbl[7] = '{1, 0, 32'h102, 32'h0, 2, 32'h77, 0, 2, 3, 0, 32'h77};
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        addr_i = 32'h500;
        #1;
        chk("nonmem_stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        chk("nonmem_req", {31'd0, mem_req}, 32'd0);
        chk("nonmem_done", {31'd0, done_o}, 32'd0);
      end
      run_op(tbl[i]);
    end

    // Reset during the second BUSY cycle, then a late ack.
    MemRead_i = 1'b1;
    addr_i    = 32'h400;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    MemRead_i = 1'b0;
    #1;
    chk("rstbusy_req", {31'd0, mem_req}, 32'd0);
    chk("rstbusy_stall", {31'd0, stall}, 32'd0);
    chk("rstbusy_rdata", rdata_o, 32'd0);
    @(posedge clk); #1;
    mem_ack   = 1'b1;
    mem_rdata = 32'h9999_8888;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("late_ack_done", {31'd0, done_o}, 32'd0);
    chk("late_ack_rdata", rdata_o, 32'd0);
    @(posedge clk); #1;
    chk("late_ack_done2", {31'd0, done_o}, 32'd0);
    last_rd = 32'd0;

    for (int n = 0; n < 40; n++) begin
      r.rd    = $urandom_range(0, 1);
      r.wr    = r.rd ? 1'($urandom_range(0, 1)) : 1'b1;
      r.addr  = $urandom & 32'hFFFF_FFFC;
      r.wdata = $urandom;
      r.dly   = $urandom_range(0, 6);
      r.rin   = $urandom;
      r.stray = 1'($urandom_range(0, 1));
      model(r.rd, r.wr, r.addr, r.dly, r.rin, last_rd,
            r.exp_req, r.exp_stall, r.exp_err, r.exp_rdata);
      run_op(r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
